// File: rtl/vid_mux_sched_if.sv
// rtl/vid_mux_sched_if.sv - control/status bundle between host, mux and the source scheduler
interface vid_mux_sched_if #(
    parameter int NIN     = 5,
    parameter int LGDWELL = 8
);
    localparam int SW = $clog2(NIN);

    logic [NIN-1:0]     i_src_eof;
    logic               i_out_eof;
    logic               i_auto;
    logic [SW-1:0]      i_manual_sel;
    logic [LGDWELL-1:0] i_dwell;
    logic [SW-1:0]      o_select;
    logic [NIN-1:0]     o_alive;
    logic               o_switch;
    logic               o_mode_auto;

    modport master (
        output i_src_eof, i_out_eof, i_auto, i_manual_sel, i_dwell,
        input  o_select, o_alive, o_switch, o_mode_auto
    );

    modport slave (
        input  i_src_eof, i_out_eof, i_auto, i_manual_sel, i_dwell,
        output o_select, o_alive, o_switch, o_mode_auto
    );
endinterface

// File: rtl/vid_mux_sched.sv
// rtl/vid_mux_sched.sv - liveness tracking and manual/round-robin source selection for the video mux
module vid_mux_sched #(
    parameter int NIN        = 5,
    parameter int LGTIMEOUT  = 24,
    parameter int LGDWELL    = 8,
    parameter int DEF_SELECT = 0
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESET,
    vid_mux_sched_if.slave      bus
);
    localparam int SW = $clog2(NIN);
    localparam logic [SW-1:0] DEF_SEL =
        (DEF_SELECT >= 0 && DEF_SELECT < NIN) ? SW'(DEF_SELECT) : '0;
    localparam logic [LGTIMEOUT-1:0] TMAX = '1;

    logic [NIN-1:0]     alive_r;
    logic [NIN-1:0]     alive_nxt;
    logic [SW-1:0]      sel_r;
    logic [SW-1:0]      sel_nxt;
    logic [LGDWELL-1:0] fcnt;
    logic [LGDWELL-1:0] fcnt_nxt;
    logic               switch_r;
    logic               mode_r;

    // Per-source timer saturates at all-ones, which doubles as the "dead" marker.
    for (genvar k = 0; k < NIN; k++) begin : g_live
        logic [LGTIMEOUT-1:0] timer;
        logic [LGTIMEOUT-1:0] timer_nxt;

        always_comb begin
            timer_nxt = timer;
            if (bus.i_src_eof[k])
                timer_nxt = '0;
            else if (timer != TMAX)
                timer_nxt = timer + 1'b1;
        end

        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET)
                timer <= TMAX;
            else
                timer <= timer_nxt;
        end

        assign alive_nxt[k] = (timer_nxt != TMAX);
    end

    // First live source after sel_r, wrapping; the lowest offset wins.
    logic [SW-1:0] cand_sel;
    logic          cand_found;
    int            idx;

    always_comb begin
        cand_sel   = sel_r;
        cand_found = 1'b0;
        idx        = 0;
        for (int k = NIN - 1; k >= 1; k--) begin
            idx = int'(sel_r) + k;
            if (idx >= NIN)
                idx = idx - NIN;
            if (alive_r[idx]) begin
                cand_found = 1'b1;
                cand_sel   = SW'(idx);
            end
        end
    end

    logic [LGDWELL-1:0] dwell_m1;
    logic               rot_trig;
    logic               loss_trig;
    logic               manual_ok;

    assign dwell_m1  = (bus.i_dwell == '0) ? '0 : bus.i_dwell - 1'b1;
    assign rot_trig  = bus.i_out_eof && (fcnt >= dwell_m1);
    assign loss_trig = !alive_r[sel_r];
    assign manual_ok = (32'(bus.i_manual_sel) < NIN);

    always_comb begin
        sel_nxt  = sel_r;
        fcnt_nxt = fcnt;
        if (!mode_r) begin
            fcnt_nxt = '0;
            if (manual_ok)
                sel_nxt = bus.i_manual_sel;
        end else if (rot_trig || loss_trig) begin
            if (cand_found) begin
                sel_nxt  = cand_sel;
                fcnt_nxt = '0;
            end else if (rot_trig) begin
                fcnt_nxt = '0;
            end else if (bus.i_out_eof) begin
                fcnt_nxt = fcnt + 1'b1;
            end
        end else if (bus.i_out_eof) begin
            fcnt_nxt = fcnt + 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            sel_r    <= DEF_SEL;
            fcnt     <= '0;
            switch_r <= 1'b0;
            mode_r   <= 1'b0;
            alive_r  <= '0;
        end else begin
            sel_r    <= sel_nxt;
            fcnt     <= fcnt_nxt;
            switch_r <= (sel_nxt != sel_r);
            mode_r   <= bus.i_auto;
            alive_r  <= alive_nxt;
        end
    end

    assign bus.o_select    = sel_r;
    assign bus.o_alive     = alive_r;
    assign bus.o_switch    = switch_r;
    assign bus.o_mode_auto = mode_r;
endmodule

// File: tb/tb_vid_mux_sched.sv
// tb/tb_vid_mux_sched.sv - self-checking bench for vid_mux_sched against a last-eof-time reference model
module tb_vid_mux_sched;
    localparam int NIN   = 5;
    localparam int LGTO  = 4;
    localparam int TOUT  = (1 << LGTO) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vid_mux_sched_if #(.NIN(NIN), .LGDWELL(8)) bus ();

    vid_mux_sched #(.NIN(NIN), .LGTIMEOUT(LGTO), .LGDWELL(8), .DEF_SELECT(0)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_eof [NIN];
    int m_sel, m_fcnt;
    bit m_alive [NIN];
    bit m_sw, m_mode;
    int last2 = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NIN; k++) begin
            last_eof[k] = -1;
            m_alive[k]  = 1'b0;
        end
        m_sel = 0; m_fcnt = 0; m_sw = 1'b0; m_mode = 1'b0;
    endtask

    // One clock edge of the scheduling rules, evaluated from pre-edge state.
    task automatic model_step();
        int nsel, nf, deff, cand;
        bit rot, loss, found;
        nsel = m_sel; nf = m_fcnt;
        if (!m_mode) begin
            nf = 0;
            if (int'(bus.i_manual_sel) < NIN) nsel = int'(bus.i_manual_sel);
        end else begin
            deff  = (bus.i_dwell == 0) ? 1 : int'(bus.i_dwell);
            rot   = bus.i_out_eof && (m_fcnt >= deff - 1);
            loss  = !m_alive[m_sel];
            found = 1'b0; cand = m_sel;
            for (int k = 1; k < NIN; k++)
                if (!found && m_alive[(m_sel + k) % NIN]) begin
                    found = 1'b1; cand = (m_sel + k) % NIN;
                end
            if (rot || loss) begin
                if (found) begin nsel = cand; nf = 0; end
                else if (rot) nf = 0;
                else if (bus.i_out_eof) nf = m_fcnt + 1;
            end else if (bus.i_out_eof) nf = m_fcnt + 1;
        end
        m_sw   = (nsel != m_sel);
        m_mode = bus.i_auto;
        m_sel  = nsel;
        m_fcnt = nf;
        for (int k = 0; k < NIN; k++) begin
            if (bus.i_src_eof[k]) last_eof[k] = cyc;
            m_alive[k] = (last_eof[k] >= 0) && (cyc - last_eof[k] < TOUT);
        end
    endtask

    task automatic check_all();
        logic [NIN-1:0] ea;
        for (int k = 0; k < NIN; k++) ea[k] = m_alive[k];
        chk("model_select", int'(bus.o_select), m_sel);
        chk("model_alive", int'(bus.o_alive), int'(ea));
        chk("model_switch", int'(bus.o_switch), int'(m_sw));
        chk("model_mode", int'(bus.o_mode_auto), int'(m_mode));
        chk("select_range", int'(int'(bus.o_select) < NIN), 1);
    endtask

    task automatic tick(input logic [NIN-1:0] se, input logic oe);
        bus.i_src_eof = se;
        bus.i_out_eof = oe;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            if (se[2]) last2 = cyc;
            model_step();
        end
        #1;
        check_all();
    endtask

    function automatic logic [NIN-1:0] pat(input logic [NIN-1:0] mask);
        logic [NIN-1:0] p;
        for (int k = 0; k < NIN; k++) p[k] = mask[k] && (((cyc + 1 + k) % 8) == 0);
        return p;
    endfunction

    typedef struct {
        logic       auto_m;
        logic [2:0] msel;
        logic [2:0] exp_sel;
        logic       exp_sw;
    } vec_t;
    vec_t tbl [8];

    int sw_q [$];
    int bad;

    initial begin
        tbl[0] = '{1'b0, 3'd0, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 3'd3, 3'd3, 1'b1};
        tbl[2] = '{1'b0, 3'd3, 3'd3, 1'b0};
        tbl[3] = '{1'b0, 3'd7, 3'd3, 1'b0};
        tbl[4] = '{1'b0, 3'd1, 3'd1, 1'b1};
        tbl[5] = '{1'b0, 3'd5, 3'd1, 1'b0};
        tbl[6] = '{1'b0, 3'd4, 3'd4, 1'b1};
        tbl[7] = '{1'b0, 3'd3, 3'd3, 1'b1};

        bus.i_src_eof = '0; bus.i_out_eof = 1'b0; bus.i_auto = 1'b0;
        bus.i_manual_sel = '0; bus.i_dwell = 8'd2;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_select", int'(bus.o_select), 0);
        chk("reset_alive", int'(bus.o_alive), 0);
        chk("reset_switch", int'(bus.o_switch), 0);
        chk("reset_mode", int'(bus.o_mode_auto), 0);
        rst = 1'b0;

        // Idle: everything dead, no switching.
        for (int i = 0; i < 20; i++) begin
            tick('0, 1'b0);
            chk("idle_switch", int'(bus.o_switch), 0);
            chk("idle_alive", int'(bus.o_alive), 0);
        end

        // Manual selection table.
        for (int i = 0; i < 8; i++) begin
            bus.i_auto = tbl[i].auto_m;
            bus.i_manual_sel = tbl[i].msel;
            tick('0, 1'b0);
            chk("tbl_select", int'(bus.o_select), int'(tbl[i].exp_sel));
            chk("tbl_switch", int'(bus.o_switch), int'(tbl[i].exp_sw));
        end

        // Auto rotation over live sources 0,2,4.
        bus.i_manual_sel = 3'd0; bus.i_dwell = 8'd2;
        for (int i = 0; i < 16; i++) tick(pat(5'b10101), 1'b0);
        bus.i_auto = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick(pat(5'b10101), ((cyc + 1) % 5) == 0);
            if (bus.o_switch) sw_q.push_back(int'(bus.o_select));
        end
        chk("rot_count", int'(sw_q.size() >= 3), 1);
        if (sw_q.size() >= 3) begin
            chk("rot_first", sw_q[0], 2);
            chk("rot_second", sw_q[1], 4);
            chk("rot_wrap", sw_q[2], 0);
        end
        bad = 0;
        foreach (sw_q[i]) if (sw_q[i] == 1 || sw_q[i] == 3) bad++;
        chk("rot_skip_dead", bad, 0);

        // Loss of the selected source forces an advance without out_eof.
        bus.i_auto = 1'b0; bus.i_manual_sel = 3'd2;
        tick(pat(5'b10101), 1'b0);
        tick(pat(5'b10101), 1'b0);
        bus.i_auto = 1'b1;
        for (int i = 0; i < 40 && bus.o_alive[2]; i++) tick(pat(5'b10001), 1'b0);
        chk("loss_alive_drop", int'(bus.o_alive[2]), 0);
        chk("loss_timeout", cyc - last2, TOUT);
        chk("loss_sel_before", int'(bus.o_select), 2);
        tick(pat(5'b10001), 1'b0);
        chk("loss_select", int'(bus.o_select), 4);
        chk("loss_switch", int'(bus.o_switch), 1);

        // Only the selected source alive, dwell 0.
        bus.i_dwell = 8'd0;
        for (int i = 0; i < 20; i++) tick(pat(5'b10000), 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(pat(5'b10000), 1'b1);
            chk("solo_select", int'(bus.o_select), 4);
            chk("solo_switch", int'(bus.o_switch), 0);
            tick(pat(5'b10000), 1'b0);
        end
        for (int i = 0; i < 20 && !bus.o_alive[1]; i++) tick(pat(5'b10010), 1'b0);
        chk("newsrc_alive", int'(bus.o_alive[1]), 1);
        chk("newsrc_hold", int'(bus.o_select), 4);
        tick(pat(5'b10010), 1'b1);
        chk("newsrc_select", int'(bus.o_select), 1);
        chk("newsrc_switch", int'(bus.o_switch), 1);

        // Asynchronous reset mid-rotation.
        bus.i_dwell = 8'd1;
        for (int i = 0; i < 20; i++) tick(pat(5'b10111), ((cyc + 1) % 3) == 0);
        rst = 1'b1;
        #1;
        chk("areset_select", int'(bus.o_select), 0);
        chk("areset_alive", int'(bus.o_alive), 0);
        chk("areset_switch", int'(bus.o_switch), 0);
        chk("areset_mode", int'(bus.o_mode_auto), 0);
        model_reset();
        tick(pat(5'b11111), 1'b1);
        tick(pat(5'b11111), 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick('0, 1'b0);
            chk("post_reset_dead", int'(bus.o_alive), 0);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [NIN-1:0] se;
            if ($urandom_range(0, 49) == 0) bus.i_auto = ~bus.i_auto;
            if ($urandom_range(0, 19) == 0) bus.i_manual_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) bus.i_dwell = 8'($urandom_range(0, 3));
            for (int k = 0; k < NIN; k++) se[k] = ($urandom_range(0, 9) == 0);
            if (i > 1500) se[3:0] = '0;
            tick(se, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
